sd_spi_ctrl: RTL and testbench
==============================

Name: sd_spi_ctrl

Overview:
- Sequences the SD-card SPI link behind the SD command/data ports of the memory/port decoder.
- Consumes the decoder's one-clock `sd_signal` strobe, `sd_cmd` and `sd_out`; returns `sd_din`, `sd_busy` and `sd_timeout`.
- Executes card power-up clocking, chip-select control and full-duplex byte exchange in SPI mode 0.
- Sits between the port decoder and the SD card pins, clocked by the CPU clock.

Parameters:
- HALF_SLOW, 63, CPU clocks per SCLK half-period during the init sequence (≈400 kHz at 50 MHz).
- HALF_FAST, 2, CPU clocks per SCLK half-period during byte transfers.
- INIT_PULSES, 80, SCLK pulses emitted by the init command.
- TIMEOUT, 25000000, idle clocks with CS asserted before `sd_timeout` sets.

Ports:
- clock  in  1  CPU clock
- reset_n  in  1  synchronous active-low reset
- sd_signal  in  1  command strobe; a command is accepted on a 0->1 transition
- sd_cmd  in  2  0=init, 1=exchange byte, 2=CS assert, 3=CS deassert
- sd_out  in  8  byte to transmit for cmd 1
- sd_din  out  8  last received byte
- sd_busy  out  1  =1 while a command executes
- sd_timeout  out  1  =1 after the watchdog expires
- spi_cs_n  out  1  card chip select, active low
- spi_sclk  out  1  SPI clock, idles low
- spi_mosi  out  1  SPI data to card
- spi_miso  in  1  SPI data from card

Behaviour:
- Reset is synchronous: reset_n=0 sampled at posedge.
- Reset values: spi_cs_n=1, spi_sclk=0, spi_mosi=1, sd_din=8'hFF, sd_busy=0, sd_timeout=0, state IDLE, all counters 0.
- Reset overrides any state; a transfer in progress is abandoned with no partial byte written to sd_din.
- Edge detect: sig_q registers sd_signal every clock; start = sd_signal & ~sig_q.
- start is accepted only in IDLE. A start while sd_busy=1 is dropped with no queuing.
- sd_cmd and sd_out are latched in the accepting cycle.
- Accepted command: sd_busy=1 from the next clock.
- Any accepted command clears sd_timeout and the watchdog counter.
- States: IDLE, INIT, XFER, DONE.
- Cmd 2 (CS assert): IDLE -> DONE. spi_cs_n=0 on the next clock; busy for exactly 1 clock.
- Cmd 3 (CS deassert): IDLE -> DONE. spi_cs_n=1 on the next clock; busy for exactly 1 clock.
- Cmd 0 (INIT), entry: IDLE -> INIT. Forces spi_cs_n=1 and spi_mosi=1.
- Cmd 0 (INIT), clocking: emits INIT_PULSES full SCLK periods, each half-period HALF_SLOW clocks, SCLK low first.
- Cmd 0 (INIT), exit: then -> DONE. Busy duration = 2*INIT_PULSES*HALF_SLOW + 1 clocks.
- Cmd 1 (XFER), entry: IDLE -> XFER. Shift register loaded with sd_out; spi_mosi = bit7 on entry.
- Cmd 1 (XFER), per bit, MSB first, mode 0:
  - SCLK low for HALF_FAST clocks.
  - SCLK rises: spi_miso is sampled into the receive register on that same clock.
  - SCLK high for HALF_FAST clocks.
  - SCLK falls: next bit is driven onto spi_mosi.
- Cmd 1 (XFER), exit: after 8 bits, SCLK is low, spi_mosi returns to 1, sd_din <= received byte, -> DONE.
- Cmd 1 does not alter spi_cs_n; an exchange with CS deasserted still clocks.
- Cmd 1 busy duration = 16*HALF_FAST + 1 clocks.
- DONE: sd_busy=0 on the following clock, -> IDLE.
- Watchdog: in IDLE with spi_cs_n=0, the counter increments each clock.
- Watchdog expiry: on reaching TIMEOUT, sd_timeout=1 and the counter saturates.
- Watchdog with spi_cs_n=1: counter held at 0; sd_timeout keeps its value until the next accepted command.
- Divider: half-period counter reloads at each SCLK edge. Width covers max(HALF_SLOW, HALF_FAST).
- Bit counter: 3 bits (XFER) or 8 bits (INIT); wraps are never observable outside their state.
- sd_signal held high for several clocks: accepted once.
- start on the same clock as reset_n=0: ignored.

Test Plan:
- Bench parameters: HALF_SLOW=4, HALF_FAST=2, INIT_PULSES=80, TIMEOUT=1000.
- Reset then cmd 0 strobe -> spi_cs_n=1 and mosi=1 throughout; exactly 80 SCLK rising edges, each period 8 clocks; sd_busy high for 641 clocks; sd_din stays 8'hFF.
- Cmd 2, then cmd 1 with sd_out=8'hA5, MISO model returning 8'h3C -> mosi bits 1,0,1,0,0,1,0,1 stable at each rising edge; sd_din=8'h3C when busy falls; busy 33 clocks; cs_n stays 0.
- Cmd 1 strobe issued while an exchange is busy -> dropped: only one byte clocked, sd_din reflects the first exchange only.
- Cmd 2, then idle 1000 clocks -> sd_timeout=1. Next cmd 3 -> sd_timeout=0 and cs_n=1; a further 2000 idle clocks leave sd_timeout=0.
- reset_n=0 asserted on bit 4 of an exchange -> next clock: busy=0, sclk=0, cs_n=1, mosi=1, sd_din=8'hFF. A following cmd 1 completes normally.
- sd_signal held high 5 clocks with cmd 1 -> exactly one exchange (8 SCLK pulses).

Source files
------------

// File: rtl/sd_spi_ctrl_if.sv
// Decoder-side command/status bundle for the SD SPI controller.
// master = port decoder, slave = sd_spi_ctrl.
interface sd_spi_ctrl_if;
   logic       sd_signal;
   logic [1:0] sd_cmd;
   logic [7:0] sd_out;
   logic [7:0] sd_din;
   logic       sd_busy;
   logic       sd_timeout;

   modport master (
      output sd_signal, sd_cmd, sd_out,
      input  sd_din, sd_busy, sd_timeout
   );

   modport slave (
      input  sd_signal, sd_cmd, sd_out,
      output sd_din, sd_busy, sd_timeout
   );
endinterface

// File: rtl/sd_spi_ctrl.sv
// SD-card SPI sequencer: power-up clocking, chip-select control and
// mode-0 full-duplex byte exchange, with a CS-asserted idle watchdog.
module sd_spi_ctrl #(
   parameter int HALF_SLOW   = 63,
   parameter int HALF_FAST   = 2,
   parameter int INIT_PULSES = 80,
   parameter int TIMEOUT     = 25000000
) (
   input  logic        clock,
   input  logic        reset_n,
   sd_spi_ctrl_if.slave sd,
   output logic        spi_cs_n,
   output logic        spi_sclk,
   output logic        spi_mosi,
   input  logic        spi_miso
);

   localparam int HALF_MAX = (HALF_SLOW > HALF_FAST) ? HALF_SLOW : HALF_FAST;
   localparam int DIV_W    = $clog2(HALF_MAX + 1);
   localparam int WD_W     = $clog2(TIMEOUT + 1);

   localparam logic [DIV_W-1:0] SLOW_RLD  = DIV_W'(HALF_SLOW - 1);
   localparam logic [DIV_W-1:0] FAST_RLD  = DIV_W'(HALF_FAST - 1);
   localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(1);
   localparam logic [7:0]       INIT_LAST = 8'(INIT_PULSES - 1);
   localparam logic [WD_W-1:0]  WD_MAX    = WD_W'(TIMEOUT);
   localparam logic [WD_W-1:0]  WD_ONE    = WD_W'(1);

   typedef enum logic [1:0] {IDLE, INIT, XFER, DONE} state_t;

   state_t           state;
   logic             sig_q;
   logic             start;
   logic [7:0]       shreg;
   logic [7:0]       rxreg;
   logic [DIV_W-1:0] div;
   logic [7:0]       bitcnt;
   logic [7:0]       din_q;
   logic             busy_q;
   logic             timeout_q;
   logic [WD_W-1:0]  wd;

   always_comb start = sd.sd_signal & ~sig_q;

   assign sd.sd_din     = din_q;
   assign sd.sd_busy    = busy_q;
   assign sd.sd_timeout = timeout_q;

   always_ff @(posedge clock) begin
      // Edge detector keeps tracking through reset so a strobe held across
      // reset release is not seen as a fresh command.
      sig_q <= sd.sd_signal;
      if (!reset_n) begin
         state     <= IDLE;
         spi_cs_n  <= 1'b1;
         spi_sclk  <= 1'b0;
         spi_mosi  <= 1'b1;
         shreg     <= '0;
         rxreg     <= '0;
         div       <= '0;
         bitcnt    <= '0;
         din_q     <= 8'hFF;
         busy_q    <= 1'b0;
         timeout_q <= 1'b0;
         wd        <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  busy_q    <= 1'b1;
                  timeout_q <= 1'b0;
                  wd        <= '0;
                  bitcnt    <= '0;
                  case (sd.sd_cmd)
                     2'd0: begin
                        state    <= INIT;
                        spi_cs_n <= 1'b1;
                        spi_mosi <= 1'b1;
                        spi_sclk <= 1'b0;
                        div      <= SLOW_RLD;
                     end
                     2'd1: begin
                        state    <= XFER;
                        shreg    <= sd.sd_out;
                        spi_mosi <= sd.sd_out[7];
                        spi_sclk <= 1'b0;
                        div      <= FAST_RLD;
                     end
                     2'd2: begin
                        state    <= DONE;
                        spi_cs_n <= 1'b0;
                     end
                     default: begin
                        state    <= DONE;
                        spi_cs_n <= 1'b1;
                     end
                  endcase
               end else if (spi_cs_n) begin
                  wd <= '0;
               end else if (wd != WD_MAX) begin
                  wd <= wd + WD_ONE;
                  if (wd == WD_MAX - WD_ONE)
                     timeout_q <= 1'b1;
               end
            end

            INIT: begin
               if (div != '0) begin
                  div <= div - DIV_ONE;
               end else begin
                  div      <= SLOW_RLD;
                  spi_sclk <= ~spi_sclk;
                  // A pulse is complete on its falling edge.
                  if (spi_sclk) begin
                     if (bitcnt == INIT_LAST)
                        state <= DONE;
                     else
                        bitcnt <= bitcnt + 8'd1;
                  end
               end
            end

            XFER: begin
               if (div != '0) begin
                  div <= div - DIV_ONE;
               end else begin
                  div <= FAST_RLD;
                  if (!spi_sclk) begin
                     spi_sclk <= 1'b1;
                     rxreg    <= {rxreg[6:0], spi_miso};
                  end else begin
                     spi_sclk <= 1'b0;
                     if (bitcnt[2:0] == 3'd7) begin
                        spi_mosi <= 1'b1;
                        din_q    <= rxreg;
                        state    <= DONE;
                     end else begin
                        bitcnt   <= bitcnt + 8'd1;
                        shreg    <= {shreg[6:0], 1'b0};
                        spi_mosi <= shreg[6];
                     end
                  end
               end
            end

            DONE: begin
               busy_q <= 1'b0;
               state  <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sd_spi_ctrl.sv
// Scoreboard bench for sd_spi_ctrl: stimulus pushes expected command results,
// a monitor measures each busy window and compares on its falling edge.
module tb_sd_spi_ctrl;

   localparam int H_SLOW = 4;
   localparam int H_FAST = 2;
   localparam int PULSES = 80;
   localparam int WD_LIM = 1000;

   logic clock = 1'b0;
   logic reset_n;
   logic spi_cs_n, spi_sclk, spi_mosi, spi_miso;
   logic [7:0] mreg = 8'hFF;

   sd_spi_ctrl_if sd_bus ();

   sd_spi_ctrl #(
      .HALF_SLOW  (H_SLOW),
      .HALF_FAST  (H_FAST),
      .INIT_PULSES(PULSES),
      .TIMEOUT    (WD_LIM)
   ) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .sd      (sd_bus.slave),
      .spi_cs_n(spi_cs_n),
      .spi_sclk(spi_sclk),
      .spi_mosi(spi_mosi),
      .spi_miso(spi_miso)
   );

   always #5 clock = ~clock;

   // Card model: presents MSB first, advances on each SCLK falling edge.
   assign spi_miso = mreg[7];
   always @(negedge spi_sclk) mreg = {mreg[6:0], 1'b1};

   typedef struct {
      logic [7:0] din;
      int         len;
      int         rises;
      int         per;
      logic [7:0] mosi;
      bit         chk_mosi;
      logic       cs_end;
      bit         init;
   } exp_t;

   exp_t q[$];
   int   tests = 0;
   int   fails = 0;
   bit   abort = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   // Monitor
   logic       busy_p = 1'b0, sclk_p = 1'b0;
   int         len, rises, last, dmin, dmax;
   logic [7:0] mosi_cap;
   bit         lowseen;
   exp_t       e;

   always @(negedge clock) begin
      if (sd_bus.sd_busy && !busy_p) begin
         len = 0; rises = 0; last = 0; dmin = 1000000; dmax = 0;
         mosi_cap = '0; lowseen = 0;
      end
      if (sd_bus.sd_busy) begin
         len++;
         if (spi_sclk && !sclk_p) begin
            if (rises > 0) begin
               if (len - last < dmin) dmin = len - last;
               if (len - last > dmax) dmax = len - last;
            end
            mosi_cap = {mosi_cap[6:0], spi_mosi};
            rises++;
            last = len;
         end
         if (!spi_cs_n || !spi_mosi) lowseen = 1;
      end
      if (!sd_bus.sd_busy && busy_p && !abort) begin
         if (q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected completion: got len %0d rises %0d, expected no command", len, rises);
         end else begin
            e = q.pop_front();
            check("sd_din", sd_bus.sd_din, e.din);
            check("busy length", len, e.len);
            check("sclk rises", rises, e.rises);
            check("cs_n at end", spi_cs_n, e.cs_end);
            check("sclk idle low", spi_sclk, 1'b0);
            check("mosi idle high", spi_mosi, 1'b1);
            if (e.rises >= 2) begin
               check("sclk period min", dmin, e.per);
               check("sclk period max", dmax, e.per);
            end
            if (e.chk_mosi) check("mosi bits", mosi_cap, e.mosi);
            if (e.init) check("init cs/mosi low seen", lowseen, 1'b0);
         end
      end
      busy_p = sd_bus.sd_busy;
      sclk_p = spi_sclk;
   end

   function automatic exp_t mk(input logic [7:0] din, input int len, input int rises,
                               input int per, input logic [7:0] mosi, input bit chk_mosi,
                               input logic cs_end, input bit init);
      exp_t r;
      r.din = din; r.len = len; r.rises = rises; r.per = per;
      r.mosi = mosi; r.chk_mosi = chk_mosi; r.cs_end = cs_end; r.init = init;
      return r;
   endfunction

   task automatic issue(input logic [1:0] c, input logic [7:0] d, input int hold);
      sd_bus.sd_cmd    = c;
      sd_bus.sd_out    = d;
      sd_bus.sd_signal = 1'b1;
      repeat (hold) @(negedge clock);
      sd_bus.sd_signal = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      while (sd_bus.sd_busy && n < 2000) begin
         @(negedge clock);
         n++;
      end
      if (n >= 2000) begin
         tests++;
         fails++;
         $display("FAIL %s: busy still high after %0d cycles, expected completion", name, n);
      end
      @(negedge clock);
   endtask

   localparam int XLEN = 16 * H_FAST + 1;

   initial begin
      reset_n          = 1'b0;
      sd_bus.sd_signal = 1'b0;
      sd_bus.sd_cmd    = 2'd0;
      sd_bus.sd_out    = 8'h00;
      repeat (3) @(negedge clock);
      check("reset cs_n", spi_cs_n, 1'b1);
      check("reset sclk", spi_sclk, 1'b0);
      check("reset mosi", spi_mosi, 1'b1);
      check("reset sd_din", sd_bus.sd_din, 8'hFF);
      check("reset busy", sd_bus.sd_busy, 1'b0);
      check("reset timeout", sd_bus.sd_timeout, 1'b0);
      reset_n = 1'b1;
      @(negedge clock);

      // Power-up clocking
      q.push_back(mk(8'hFF, 2 * PULSES * H_SLOW + 1, PULSES, 2 * H_SLOW, 8'h00, 0, 1'b1, 1));
      issue(2'd0, 8'h00, 1);
      wait_done("init");

      // CS assert, then exchange with a dropped strobe in the middle
      q.push_back(mk(8'hFF, 1, 0, 0, 8'h00, 0, 1'b0, 0));
      issue(2'd2, 8'h00, 1);
      wait_done("cs assert");
      mreg = 8'h3C;
      q.push_back(mk(8'h3C, XLEN, 8, 2 * H_FAST, 8'hA5, 1, 1'b0, 0));
      issue(2'd1, 8'hA5, 1);
      repeat (6) @(negedge clock);
      issue(2'd1, 8'h00, 1);
      wait_done("xfer A5");

      // Watchdog expiry with CS held asserted
      repeat (WD_LIM - 12) @(negedge clock);
      check("timeout before limit", sd_bus.sd_timeout, 1'b0);
      repeat (20) @(negedge clock);
      check("timeout after limit", sd_bus.sd_timeout, 1'b1);

      q.push_back(mk(8'h3C, 1, 0, 0, 8'h00, 0, 1'b1, 0));
      issue(2'd3, 8'h00, 1);
      wait_done("cs deassert");
      check("timeout cleared", sd_bus.sd_timeout, 1'b0);
      repeat (2 * WD_LIM) @(negedge clock);
      check("timeout stays clear", sd_bus.sd_timeout, 1'b0);

      // Reset in the middle of an exchange
      q.push_back(mk(8'h3C, 1, 0, 0, 8'h00, 0, 1'b0, 0));
      issue(2'd2, 8'h00, 1);
      wait_done("cs assert 2");
      mreg = 8'h0F;
      issue(2'd1, 8'hFF, 1);
      repeat (16) @(negedge clock);
      abort   = 1;
      reset_n = 1'b0;
      @(negedge clock);
      check("abort busy", sd_bus.sd_busy, 1'b0);
      check("abort sclk", spi_sclk, 1'b0);
      check("abort cs_n", spi_cs_n, 1'b1);
      check("abort mosi", spi_mosi, 1'b1);
      check("abort sd_din", sd_bus.sd_din, 8'hFF);
      reset_n = 1'b1;
      @(negedge clock);
      abort = 0;

      mreg = 8'h96;
      q.push_back(mk(8'h96, XLEN, 8, 2 * H_FAST, 8'hC3, 1, 1'b1, 0));
      issue(2'd1, 8'hC3, 1);
      wait_done("xfer after reset");

      // Strobe held high for several clocks
      mreg = 8'h81;
      q.push_back(mk(8'h81, XLEN, 8, 2 * H_FAST, 8'h5A, 1, 1'b1, 0));
      issue(2'd1, 8'h5A, 5);
      wait_done("held strobe");
      repeat (50) @(negedge clock);

      check("scoreboard drained", q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL global timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
